// File: rtl/data_mem_if.sv
// data_mem_if -- CPU data-port bus plus the TX byte stream of the data memory.
//
// Signals:
//   addr      32  byte address from the CPU (low two bits ignored)
//   wdata     32  full-word write data
//   wr         1  write strobe, commits on the rising clock edge
//   data      32  combinational read data
//   tx_data    8  head byte of the transmit FIFO
//   tx_valid   1  transmit FIFO non-empty
//   tx_ready   1  consumer accepts the head byte on the rising edge
//
// Modports:
//   master  CPU / consumer side (drives addr, wdata, wr, tx_ready)
//   slave   memory side (drives data, tx_data, tx_valid)
interface data_mem_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        output addr, wdata, wr, tx_ready,
        input  data, tx_data, tx_valid
    );

    modport slave (
        input  addr, wdata, wr, tx_ready,
        output data, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem.sv
// data_mem -- word-addressed data memory with a small MMIO block.
//
// Address map (addr[1:0] ignored, all accesses are whole words):
//   0 .. RAM_WORDS*4-1  RAM, asynchronous read, write on the edge with wr=1
//   0x8000_0000         TXDATA: write pushes wdata[7:0] into the TX FIFO, reads 0
//   0x8000_0004         STATUS: bit0 full, bit1 empty, bit2 overflow (sticky),
//                       bits[15:8] count; write with wdata[2]=1 clears overflow
//   0x8000_0008         CYCLE: free-running counter, write loads it
//   anything else       reads 0, writes ignored
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset (RAM contents are not reset)
//   bus    data_mem_if slave modport
module data_mem #(
    parameter int RAM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    data_mem_if.slave  bus
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

    localparam logic [31:0] TXDATA_ADDR = 32'h8000_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h8000_0004;
    localparam logic [31:0] CYCLE_ADDR  = 32'h8000_0008;

    logic [31:0]    ram [RAM_WORDS];
    logic [7:0]     fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [PW:0]    count;
    logic           overflow;
    logic [31:0]    cycle;

    logic [31:0]    word_addr;
    logic [AW-1:0]  ram_idx;
    logic           ram_sel;
    logic           tx_sel;
    logic           status_sel;
    logic           cycle_sel;
    logic           pop;
    logic           push_req;
    logic           push_ok;
    logic           ovf_set;
    logic           ovf_clr;
    logic [31:0]    status;
    logic [31:0]    rdata;

    // Address decode. The RAM window test uses every address bit so that
    // aliases above the window never hit the RAM.
    assign word_addr  = {bus.addr[31:2], 2'b00};
    assign ram_idx    = bus.addr[AW+1:2];
    assign ram_sel    = (bus.addr >> (AW + 2)) == 32'd0;
    assign tx_sel     = word_addr == TXDATA_ADDR;
    assign status_sel = word_addr == STATUS_ADDR;
    assign cycle_sel  = word_addr == CYCLE_ADDR;

    // A full FIFO still accepts a push when the head leaves on the same edge;
    // every other push into a full FIFO is dropped and flagged.
    assign pop      = (count != '0) && bus.tx_ready;
    assign push_req = bus.wr && tx_sel;
    assign push_ok  = push_req && ((count < FULL_COUNT) || pop);
    assign ovf_set  = push_req && !push_ok;
    assign ovf_clr  = bus.wr && status_sel && bus.wdata[2];

    // RAM storage has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (bus.wr && ram_sel) begin
            ram[ram_idx] <= bus.wdata;
        end
    end

    // FIFO storage: only the pointers and count are reset, stale bytes are
    // never visible because tx_valid follows count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.wdata[7:0];
        end
    end

    // FIFO control. Pointers wrap naturally since FIFO_DEPTH is a power of 2.
    // A set of overflow wins over a clear arriving on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Free-running cycle counter; a CPU write takes precedence over the increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle <= '0;
        end else if (bus.wr && cycle_sel) begin
            cycle <= bus.wdata;
        end else begin
            cycle <= cycle + 32'd1;
        end
    end

    assign status = {16'h0000, 8'(count), 5'b00000, overflow,
                     count == '0, count == FULL_COUNT};

    // Zero-latency read mux; TXDATA and unmapped addresses fall to 0.
    always_comb begin
        rdata = '0;
        if (ram_sel) begin
            rdata = ram[ram_idx];
        end else if (status_sel) begin
            rdata = status;
        end else if (cycle_sel) begin
            rdata = cycle;
        end
    end

    assign bus.data     = rdata;
    assign bus.tx_valid = count != '0;
    assign bus.tx_data  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem -- randomized, scoreboard-checked bench for data_mem.
//
// The stimulus process drives one bus operation per cycle, checks the
// combinational read data against a behavioural model and advances the model
// for the coming edge. Accepted TX bytes are pushed into an expected queue;
// an independent monitor pops and compares whenever the DUT hands a byte over.
module tb_data_mem;

    localparam int RAM_WORDS  = 1024;
    localparam int FIFO_DEPTH = 8;

    localparam logic [31:0] TX_A  = 32'h8000_0000;
    localparam logic [31:0] ST_A  = 32'h8000_0004;
    localparam logic [31:0] CYC_A = 32'h8000_0008;

    logic clk;
    logic rst_n;

    data_mem_if dif ();

    data_mem #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: sparse RAM, FIFO occupancy, sticky flag, counter.
    logic [31:0] ram_m [int];
    logic [7:0]  exp_q [$];
    int          mcount;
    bit          movf;
    logic [31:0] mcycle;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic bit isRam(input logic [31:0] a);
        return a < 32'(RAM_WORDS * 4);
    endfunction

    function automatic int ramIdx(input logic [31:0] a);
        return int'(a >> 2);
    endfunction

    function automatic logic [31:0] expRead(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (isRam(a)) return ram_m[ramIdx(a)];
        if (wa == ST_A) return {16'h0, 8'(mcount), 5'b0, movf, mcount == 0, mcount == FIFO_DEPTH};
        if (wa == CYC_A) return mcycle;
        return 32'h0;
    endfunction

    // Advance the model across one rising edge with the given bus inputs.
    task automatic modelEdge(input logic [31:0] a, input logic [31:0] d,
                             input logic w, input logic rdy);
        logic [31:0] wa;
        bit          pop;
        wa  = {a[31:2], 2'b00};
        pop = (mcount > 0) && rdy;
        if (w) begin
            if (isRam(a)) begin
                ram_m[ramIdx(a)] = d;
            end else if (wa == TX_A) begin
                if (mcount < FIFO_DEPTH || pop) begin
                    exp_q.push_back(d[7:0]);
                    mcount++;
                end else begin
                    movf = 1'b1;
                end
            end else if (wa == ST_A && d[2]) begin
                movf = 1'b0;
            end
        end
        if (w && wa == CYC_A) mcycle = d;
        else                  mcycle = mcycle + 32'd1;
        if (pop) mcount--;
    endtask

    task automatic modelReset();
        mcount = 0;
        movf   = 1'b0;
        mcycle = 32'h0;
        exp_q.delete();
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic rdy, input string name);
        dif.addr     = a;
        dif.wdata    = d;
        dif.wr       = w;
        dif.tx_ready = rdy;
        @(negedge clk);
        if (!isRam(a) || ram_m.exists(ramIdx(a)))
            checkOutput(name, dif.data, expRead(a));
        checkOutput("tx_valid", {31'b0, dif.tx_valid}, {31'b0, mcount != 0});
        #2;
        modelEdge(a, d, w, rdy);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: a handshake seen here completes on the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && dif.tx_valid && dif.tx_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("tx unexpected byte", {24'b0, dif.tx_data}, 32'hFFFF_FFFF);
                end else begin
                    checkOutput("tx_data", {24'b0, dif.tx_data}, {24'b0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        int guard;
        logic [31:0] a;
        logic [31:0] d;
        int op;

        rst_n        = 1'b0;
        dif.addr     = ST_A;
        dif.wdata    = 32'h0;
        dif.wr       = 1'b0;
        dif.tx_ready = 1'b1;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset tx_valid", {31'b0, dif.tx_valid}, 32'h0);
        checkOutput("reset status", dif.data, 32'h0000_0002);
        dif.addr = CYC_A;
        #1;
        checkOutput("reset cycle", dif.data, 32'h0);
        rst_n = 1'b1;

        // Write then read, including an unaligned byte address of the same word.
        applyStimulus(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, "ram write 0x10");
        applyStimulus(32'h10, 32'h0, 1'b0, 1'b0, "ram read 0x10");
        applyStimulus(32'h13, 32'h0, 1'b0, 1'b0, "ram read 0x13");
        applyStimulus(32'h13, 32'h0, 1'b0, 1'b0, "ram read 0x13 again");
        checkOutput("ram 0x13 literal", dif.data, 32'hDEAD_BEEF);

        // Overfill with the consumer stalled, then drain.
        for (int i = 1; i <= 9; i++)
            applyStimulus(TX_A, 32'(i), 1'b1, 1'b0, "txdata read");
        applyStimulus(ST_A, 32'h0, 1'b0, 1'b0, "status full+ovf");
        checkOutput("status full literal", dif.data, 32'h0000_0805);
        for (int i = 0; i < 8; i++)
            applyStimulus(ST_A, 32'h0, 1'b0, 1'b1, "status draining");
        applyStimulus(ST_A, 32'h4, 1'b1, 1'b0, "status empty");
        applyStimulus(ST_A, 32'h0, 1'b0, 1'b0, "status ovf cleared");

        // Full FIFO with a simultaneous pop accepts the push.
        for (int i = 0; i < 8; i++)
            applyStimulus(TX_A, 32'h10 + 32'(i), 1'b1, 1'b0, "txdata fill");
        applyStimulus(TX_A, 32'hAA, 1'b1, 1'b1, "push+pop full");
        applyStimulus(ST_A, 32'h0, 1'b0, 1'b0, "status after push+pop");
        for (int i = 0; i < 8; i++)
            applyStimulus(ST_A, 32'h0, 1'b0, 1'b1, "status drain aa");

        // Counter wrap.
        applyStimulus(CYC_A, 32'hFFFF_FFFE, 1'b1, 1'b0, "cycle write");
        for (int i = 0; i < 3; i++)
            applyStimulus(CYC_A, 32'h0, 1'b0, 1'b0, "cycle wrap");

        // Unmapped address: reads 0, writes never reach RAM word 0.
        applyStimulus(32'h0, 32'h1234_5678, 1'b1, 1'b0, "ram word0 write");
        applyStimulus(32'h4000_0000, 32'h0, 1'b0, 1'b0, "unmapped read");
        applyStimulus(32'h4000_0000, 32'hCAFE_F00D, 1'b1, 1'b0, "unmapped write");
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, "ram word0 unchanged");

        // Reset pulse between edges with bytes queued.
        for (int i = 0; i < 3; i++)
            applyStimulus(TX_A, 32'h40 + 32'(i), 1'b1, 1'b0, "txdata pre-reset");
        dif.wr = 1'b0;
        dif.addr = ST_A;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async reset tx_valid", {31'b0, dif.tx_valid}, 32'h0);
        checkOutput("async reset status", dif.data, 32'h0000_0002);
        dif.addr = 32'h0;
        #0;
        checkOutput("ram kept in reset", dif.data, ram_m[0]);
        modelReset();
        rst_n = 1'b1;
        applyStimulus(ST_A, 32'h0, 1'b0, 1'b0, "status after reset");
        applyStimulus(CYC_A, 32'h0, 1'b0, 1'b0, "cycle after reset");

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 7);
            d  = $urandom;
            case (op)
                0: begin
                    a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 1) == 1) a = 32'(RAM_WORDS * 4 - 1) - a;
                    applyStimulus(a, d, 1'b1, ($urandom_range(0, 2) == 0), "rand ram write");
                end
                1: begin
                    a = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 1) == 1) a = 32'(RAM_WORDS * 4 - 1) - a;
                    applyStimulus(a, d, 1'b0, ($urandom_range(0, 2) == 0), "rand ram read");
                end
                2, 3: applyStimulus(TX_A + 32'($urandom_range(0, 3)), d, 1'b1,
                                    ($urandom_range(0, 2) == 0), "rand tx push");
                4: applyStimulus(ST_A, d, 1'b0, ($urandom_range(0, 2) == 0), "rand status read");
                5: applyStimulus(ST_A, d, 1'b1, ($urandom_range(0, 2) == 0), "rand status write");
                6: applyStimulus(CYC_A, d, ($urandom_range(0, 3) == 0),
                                 ($urandom_range(0, 2) == 0), "rand cycle");
                default: begin
                    a = ($urandom_range(0, 1) == 1) ? 32'h8000_000C : (32'h4000_0000 | $urandom);
                    applyStimulus(a, d, $urandom_range(0, 1) == 1,
                                  ($urandom_range(0, 2) == 0), "rand unmapped");
                end
            endcase
        end

        // Drain whatever is left, bounded.
        guard = 0;
        while (mcount > 0 && guard < 100) begin
            applyStimulus(ST_A, 32'h0, 1'b0, 1'b1, "final drain status");
            guard++;
        end
        if (mcount > 0) checkOutput("drain timeout", 32'(mcount), 32'h0);
        applyStimulus(ST_A, 32'h0, 1'b0, 1'b0, "final status");
        checkOutput("scoreboard empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
